mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one single-port memory between the IF-stage instruction fetch and the MEM-stage load/store of the 5-stage RISC-V core. It runs a request/acknowledge transaction to memory with arbitrary wait states and a watchdog timeout. It returns read data to the winning stage and drives the stall signals that the pipeline merges with the hazard unit's stall/flush outputs. Data accesses have priority over fetches because they belong to the older instruction.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-mask width is DATA_W/8
- TIMEOUT, 16, max cycles mem_req may stay high without mem_ack (≥1, ≤255)

- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_valid or if_kill
- if_addr  in  ADDR_W  fetch address
- if_kill  in  1  one-cycle pulse; branch redirect, discard in-flight fetch
- if_rdata  out  DATA_W  fetched instruction, valid with if_valid
- if_valid  out  1  one-cycle fetch-complete pulse
- d_req  in  1  data request; held until d_done
- d_we  in  1  1 = store
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wmask  in  DATA_W/8  store byte enables
- d_rdata  out  DATA_W  load data, valid with d_done
- d_done  out  1  one-cycle data-complete pulse
- err  out  1  pulses with if_valid/d_done when the transaction timed out
- mem_req  out  1  memory request, held until mem_ack
- mem_we, mem_addr, mem_wdata, mem_wmask  out  1/ADDR_W/DATA_W/DATA_W/8  latched request fields
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  memory completion, sampled only while mem_req=1
- stall_if  out  1  if_req & ~if_valid (combinational); gates PC_EN_IF / IF-ID enable
- stall_pipe  out  1  d_req & ~d_done (combinational); freezes all pipeline registers

## Operation
- States:
  - IDLE: no transaction.
  - FETCH / DATA: mem_req=1, waiting for mem_ack.
  - RESP_F / RESP_D: completion pulse cycle.
- Arbitration at a clock edge in IDLE: d_req → DATA; else if_req → FETCH; else stay. The winning request's fields are latched into the mem_* registers at that edge. They stay stable until ack.
- In RESP_x the just-served requester is masked, because its req is still high that cycle. The other requester may be granted directly (RESP_D→FETCH if if_req, RESP_F→DATA if d_req); otherwise → IDLE.
- FETCH/DATA on mem_ack:
  - Capture mem_rdata into if_rdata/d_rdata, go to RESP_F/RESP_D, and clear the wait counter.
- FETCH/DATA without ack:
  - The wait counter increments.
  - When the count reaches TIMEOUT-1 with no ack, the transaction is forced complete: rdata=0, err set for the RESP cycle, and mem_req drops.
- if_valid/d_done and err are high only in the RESP_F/RESP_D cycle.
- Stores: d_rdata is unchanged; d_done pulses as for loads.
- Kill: an if_kill in FETCH, or in the same cycle as the fetch's mem_ack, sets kill_pend. RESP_F with kill_pend=1 gives if_valid=0 and err=0, and clears kill_pend. if_kill in IDLE, DATA or RESP_D has no effect. A fetch is never aborted on the memory side; it always runs to ack/timeout.
- A requester dropping req mid-transaction does not cancel it; the completion pulse still occurs.
- Reset (async, any state): state=IDLE, mem_req=0, mem_we=0, mem_addr/wdata/wmask=0, if_rdata=d_rdata=0, if_valid=d_done=err=0, counter=0, kill_pend=0. Memory must tolerate an abandoned request.

## Timing
- All outputs except stall_if/stall_pipe are registered.
- Request high at edge k → mem_req high from k+1.
- Zero-wait memory (ack during the first mem_req cycle): done/valid in cycle k+2, i.e. 2-cycle latency. Each wait state adds 1 cycle.
- Back-to-back throughput is one access per 2 cycles when requesters alternate. The same requester re-requesting gets at most one access per 3 cycles (RESP → IDLE → grant).
- Simultaneous d_req and if_req in IDLE: data wins, and the fetch is granted from RESP_D.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then RESP with err=1.

## Test plan
- Zero-wait fetch, if_addr=0x100, mem_rdata=0x00000013 → mem_req 1 cycle, if_valid at k+2 with if_rdata=0x13, stall_if low after.
- Simultaneous d_req (load 0x2000) and if_req (0x104), 2 wait states each → DATA served first with d_done at k+4, FETCH granted from RESP_D, if_valid at k+8. stall_pipe is high k..k+3.
- Store d_wdata=0xDEADBEEF, d_wmask=4'b0011 → mem_we=1 with fields stable through all wait cycles, d_done pulse, d_rdata unchanged.
- if_kill during a 3-wait fetch → no if_valid. A fresh if_req to 0x200 afterwards returns its own data.
- No mem_ack for a load with TIMEOUT=16 → mem_req high exactly 16 cycles, then d_done=1, err=1, d_rdata=0.
- rst_n low in mid-DATA → mem_req and all pulses 0 immediately. After release, a pending if_req is granted as in IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data requests win over fetches; each transaction is guarded by a wait-state watchdog.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                stall_if,
  output logic                stall_pipe
);

  localparam int         MASK_W    = DATA_W / 8;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_RESP_F = 3'd3;
  localparam logic [2:0] ST_RESP_D = 3'd4;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [2:0] state_r;
  logic [2:0] state_nxt_s;
  logic [7:0] wait_cnt_r;
  logic       kill_pend_r;
  logic       kill_pend_nxt_s;
  logic       grant_d_s;
  logic       grant_f_s;
  logic       fin_s;
  logic       tmo_s;
  logic       kill_s;

  assign stall_if   = if_req & ~if_valid;
  assign stall_pipe = d_req & ~d_done;
  assign kill_s     = kill_pend_r | if_kill;

  // Next-state, grant and completion decode; the just-served requester is masked in RESP.
  always_comb begin
    state_nxt_s     = state_r;
    kill_pend_nxt_s = kill_pend_r;
    grant_d_s       = 1'b0;
    grant_f_s       = 1'b0;
    fin_s           = 1'b0;
    tmo_s           = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (d_req) begin
          grant_d_s   = 1'b1;
          state_nxt_s = ST_DATA;
        end else if (if_req) begin
          grant_f_s   = 1'b1;
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH, ST_DATA: begin
        if (state_r == ST_FETCH) begin
          kill_pend_nxt_s = kill_s;
        end else begin
          kill_pend_nxt_s = kill_pend_r;
        end
        if (mem_ack) begin
          fin_s = 1'b1;
        end else if (wait_cnt_r == WAIT_LAST) begin
          fin_s = 1'b1;
          tmo_s = 1'b1;
        end else begin
          fin_s = 1'b0;
        end
        if (fin_s) begin
          state_nxt_s = (state_r == ST_FETCH) ? ST_RESP_F : ST_RESP_D;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RESP_F: begin
        kill_pend_nxt_s = 1'b0;
        if (d_req) begin
          grant_d_s   = 1'b1;
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RESP_D: begin
        if (if_req) begin
          grant_f_s   = 1'b1;
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        kill_pend_nxt_s = 1'b0;
      end
    endcase
  end

  // State, latched memory request fields, wait counter and completion pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      kill_pend_r <= 1'b0;
      wait_cnt_r  <= 8'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= {ADDR_W{1'b0}};
      mem_wdata   <= {DATA_W{1'b0}};
      mem_wmask   <= {MASK_W{1'b0}};
      if_rdata    <= {DATA_W{1'b0}};
      d_rdata     <= {DATA_W{1'b0}};
      if_valid    <= 1'b0;
      d_done      <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      kill_pend_r <= kill_pend_nxt_s;
      if_valid    <= 1'b0;
      d_done      <= 1'b0;
      err         <= 1'b0;
      if (grant_d_s) begin
        mem_req    <= 1'b1;
        mem_we     <= d_we;
        mem_addr   <= d_addr;
        mem_wdata  <= d_wdata;
        mem_wmask  <= d_wmask;
        wait_cnt_r <= 8'd0;
      end else if (grant_f_s) begin
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= if_addr;
        mem_wdata  <= {DATA_W{1'b0}};
        mem_wmask  <= {MASK_W{1'b0}};
        wait_cnt_r <= 8'd0;
      end else if (fin_s) begin
        mem_req    <= 1'b0;
        wait_cnt_r <= 8'd0;
        if (state_r == ST_FETCH) begin
          // A killed fetch still completes on the bus but is hidden from IF.
          if_rdata <= tmo_s ? {DATA_W{1'b0}} : mem_rdata;
          if_valid <= ~kill_s;
          err      <= tmo_s & ~kill_s;
        end else begin
          d_done <= 1'b1;
          err    <= tmo_s;
          if (!mem_we) begin
            d_rdata <= tmo_s ? {DATA_W{1'b0}} : mem_rdata;
          end else begin
            d_rdata <= d_rdata;
          end
        end
      end else if ((state_r == ST_FETCH) || (state_r == ST_DATA)) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_r <= 8'd0;
      end
    end
  end

endmodule
